// File: rtl/add_roundkey_stream.sv
// Streaming AddRoundKey: XORs LANE_BITS-wide beats of a 128-bit AES state with
// the matching round-key slice, behind a one-deep registered output stage.
module add_roundkey_stream #(
    parameter int LANE_BITS = 32,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [LANE_BITS-1:0] s_data,
    input  logic [127:0]         s_key,
    input  logic                 s_bypass,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LANE_BITS-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic [CNT_BITS-1:0]  blk_count
);
    localparam int BEATS = 128 / LANE_BITS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (!(LANE_BITS == 8 || LANE_BITS == 16 || LANE_BITS == 32 ||
              LANE_BITS == 64 || LANE_BITS == 128)) begin : g_bad_lane
            $fatal(1, "add_roundkey_stream: LANE_BITS must be 8, 16, 32, 64 or 128");
        end
    endgenerate

    logic [BW-1:0]        beat_cnt;
    logic [127:0]         key_q;
    logic                 bypass_q;
    logic                 accept;
    logic                 first;
    logic                 last;
    logic [127:0]         key_use;
    logic                 bypass_use;
    logic [6:0]           base;
    logic [LANE_BITS-1:0] key_lane;
    logic [LANE_BITS-1:0] next_data;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign first   = (beat_cnt == '0);
    assign last    = (beat_cnt == BW'(BEATS - 1));
    assign busy    = (beat_cnt != '0);

    // Beat 0 takes the key and bypass straight from the ports, so the first
    // lane does not wait for key_q to load.
    assign key_use    = first ? s_key : key_q;
    assign bypass_use = first ? s_bypass : bypass_q;
    assign base       = 7'(127 - int'(beat_cnt) * LANE_BITS);
    assign key_lane   = key_use[base -: LANE_BITS];
    assign next_data  = bypass_use ? s_data : (s_data ^ key_lane);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            beat_cnt  <= '0;
            key_q     <= '0;
            bypass_q  <= 1'b0;
            blk_count <= '0;
        end else if (accept) begin
            m_valid  <= 1'b1;
            m_data   <= next_data;
            m_last   <= last;
            beat_cnt <= last ? '0 : beat_cnt + BW'(1);
            if (first) begin
                key_q    <= s_key;
                bypass_q <= s_bypass;
            end
            if (last) blk_count <= blk_count + CNT_BITS'(1);
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add_roundkey_stream.sv
// Bench for add_roundkey_stream: three instances (32/128/8-bit lanes) checked
// against a block-level XOR model with a scoreboard queue.
module tb_add_roundkey_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rs, sv, mr, sb;
    logic [127:0] sd [3];
    logic [127:0] sk [3];

    logic [2:0]   sr, mv, ml, bz;
    logic [31:0]  md0;
    logic [127:0] md1;
    logic [7:0]   md2;
    logic [15:0]  bc0, bc1;
    logic [1:0]   bc2;

    add_roundkey_stream #(.LANE_BITS(32), .CNT_BITS(16)) u_l32 (
        .clk(clk), .rst(rs[0]), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0][31:0]),
        .s_key(sk[0]), .s_bypass(sb[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md0),
        .m_last(ml[0]), .busy(bz[0]), .blk_count(bc0));
    add_roundkey_stream #(.LANE_BITS(128), .CNT_BITS(16)) u_l128 (
        .clk(clk), .rst(rs[1]), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .s_key(sk[1]), .s_bypass(sb[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md1),
        .m_last(ml[1]), .busy(bz[1]), .blk_count(bc1));
    add_roundkey_stream #(.LANE_BITS(8), .CNT_BITS(2)) u_l8 (
        .clk(clk), .rst(rs[2]), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2][7:0]),
        .s_key(sk[2]), .s_bypass(sb[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md2),
        .m_last(ml[2]), .busy(bz[2]), .blk_count(bc2));

    typedef struct {
        logic [127:0] data;
        bit           last;
    } ent_t;

    int total = 0;
    int bad   = 0;
    int act, beat, blk, pct, vpct;
    logic [127:0] km;
    bit bm;
    ent_t q[$];
    logic [127:0] lg[$];

    localparam logic [127:0] ST = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;

    function automatic int lbf(int d);
        return (d == 0) ? 32 : (d == 1) ? 128 : 8;
    endfunction

    function automatic int cbf(int d);
        return (d == 2) ? 2 : 16;
    endfunction

    function automatic logic [127:0] omd(int d);
        return (d == 0) ? {96'b0, md0} : (d == 1) ? md1 : {120'b0, md2};
    endfunction

    function automatic logic [127:0] obc(int d);
        return (d == 0) ? {112'b0, bc0} : (d == 1) ? {112'b0, bc1} : {126'b0, bc2};
    endfunction

    // Lane i of a 128-bit word, MSB lane first, right-aligned.
    function automatic logic [127:0] slice(logic [127:0] v, int i, int lb);
        return (v << (i * lb)) >> (128 - lb);
    endfunction

    function automatic logic [127:0] lmask(int lb);
        return (lb == 128) ? '1 : ((128'(1) << lb) - 128'(1));
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the active instance: predict handshake, advance the model
    // across the edge, then compare every output.
    task automatic cyc(output bit acc);
        int d = act;
        int nb = 128 / lbf(d);
        bit rdy, pop, b;
        ent_t e;
        logic [127:0] k;
        mr[d] = ($urandom_range(99) < pct);
        #1;
        rdy = (q.size() == 0) || mr[d];
        if (!rs[d]) chk("s_ready", {127'b0, sr[d]}, {127'b0, rdy});
        acc = sv[d] && rdy && !rs[d];
        pop = (q.size() != 0) && mr[d];
        if (pop) lg.push_back(omd(d));
        e.data = '0;
        e.last = 1'b0;
        if (acc) begin
            k = (beat == 0) ? sk[d] : km;
            b = (beat == 0) ? sb[d] : bm;
            if (beat == 0) begin
                km = sk[d];
                bm = sb[d];
            end
            e.data = (sd[d] & lmask(lbf(d))) ^ (b ? 128'b0 : slice(k, beat, lbf(d)));
            e.last = (beat == nb - 1);
        end
        @(posedge clk);
        #1;
        if (rs[d]) begin
            q.delete();
            beat = 0;
            blk  = 0;
            km   = '0;
            bm   = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                beat++;
                if (beat == nb) begin
                    beat = 0;
                    blk++;
                end
            end
        end
        chk("m_valid", {127'b0, mv[d]}, {127'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("m_data", omd(d), q[0].data);
            chk("m_last", {127'b0, ml[d]}, {127'b0, q[0].last});
        end else if (rs[d]) begin
            chk("rst_m_data", omd(d), 128'b0);
            chk("rst_m_last", {127'b0, ml[d]}, 128'b0);
        end
        chk("busy", {127'b0, bz[d]}, {127'b0, beat != 0});
        chk("blk_count", obc(d), 128'(blk % (1 << cbf(d))));
    endtask

    task automatic push_beat(input logic [127:0] data, input logic [127:0] key, input bit byp);
        bit acc = 1'b0;
        int n = 0;
        sd[act] = data;
        sk[act] = key;
        sb[act] = byp;
        while (!acc && n < 200) begin
            sv[act] = ($urandom_range(99) < vpct);
            cyc(acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 128'(n), 128'(0));
        sv[act] = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] st, input logic [127:0] key, input bit byp);
        int lb = lbf(act);
        for (int i = 0; i < 128 / lb; i++) push_beat(slice(st, i, lb), key, byp);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        int sp = pct;
        pct = 100;
        sv[act] = 1'b0;
        while (q.size() != 0 && n < 50) begin
            cyc(acc);
            n++;
        end
        chk("drain_left", 128'(q.size()), 128'(0));
        pct = sp;
    endtask

    task automatic chk_test1_log(input string tag, input int base);
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00102030;
        exp_w[1] = 32'h40506070;
        exp_w[2] = 32'h8090a0b0;
        exp_w[3] = 32'hc0d0e0f0;
        for (int i = 0; i < 4; i++)
            chk(tag, (base + i < lg.size()) ? lg[base + i] : 128'hx, {96'b0, exp_w[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [127:0] st, key;
        rs = 3'b111; sv = 3'b000; mr = 3'b111; sb = 3'b000;
        for (int d = 0; d < 3; d++) begin
            sd[d] = '0;
            sk[d] = '0;
        end
        act = 0; pct = 100; vpct = 100; beat = 0; blk = 0; km = '0; bm = 1'b0;

        // Reset state of all three instances
        cyc(acc);
        cyc(acc);
        for (int d = 1; d < 3; d++) begin
            chk("rst_m_valid", {127'b0, mv[d]}, 128'b0);
            chk("rst_m_data", omd(d), 128'b0);
            chk("rst_m_last", {127'b0, ml[d]}, 128'b0);
            chk("rst_busy", {127'b0, bz[d]}, 128'b0);
            chk("rst_blk", obc(d), 128'b0);
        end
        rs = 3'b000;
        #1;
        for (int d = 0; d < 3; d++) chk("post_rst_s_ready", {127'b0, sr[d]}, 128'b1);

        // Known-answer block, full throughput
        lg.delete();
        send_block(ST, K, 1'b0);
        drain();
        chk("t1_count", 128'(lg.size()), 128'(4));
        chk_test1_log("t1_data", 0);
        chk("t1_blk", obc(0), 128'(1));

        // Downstream stall for 3 cycles after the first output
        lg.delete();
        push_beat(slice(ST, 0, 32), K, 1'b0);
        pct = 0;
        sd[0] = slice(ST, 1, 32);
        sv[0] = 1'b1;
        repeat (3) begin
            cyc(acc);
            chk("t3_stall_ready", {127'b0, sr[0]}, 128'b0);
            chk("t3_stall_data", omd(0), 128'h00102030);
        end
        sv[0] = 1'b0;
        pct = 100;
        for (int i = 1; i < 4; i++) push_beat(slice(ST, i, 32), K, 1'b0);
        drain();
        chk("t3_count", 128'(lg.size()), 128'(4));
        chk_test1_log("t3_data", 0);

        // Key/bypass changes mid-block are ignored; bypass on beat 0 passes data
        lg.delete();
        push_beat(slice(ST, 0, 32), K, 1'b0);
        push_beat(slice(ST, 1, 32), '1, 1'b0);
        push_beat(slice(ST, 2, 32), '1, 1'b1);
        push_beat(slice(ST, 3, 32), '1, 1'b1);
        send_block(ST, K, 1'b1);
        drain();
        chk("t4_count", 128'(lg.size()), 128'(8));
        chk_test1_log("t4_data", 0);
        for (int i = 0; i < 4; i++)
            chk("t4_bypass", (4 + i < lg.size()) ? lg[4 + i] : 128'hx, slice(ST, i, 32));

        // Reset mid-block, then a clean block
        push_beat(slice(ST, 0, 32), K, 1'b0);
        push_beat(slice(ST, 1, 32), K, 1'b0);
        rs[0] = 1'b1;
        cyc(acc);
        rs[0] = 1'b0;
        chk("t5_m_valid", {127'b0, mv[0]}, 128'b0);
        chk("t5_busy", {127'b0, bz[0]}, 128'b0);
        chk("t5_blk", obc(0), 128'b0);
        lg.delete();
        send_block(ST, K, 1'b0);
        drain();
        chk("t5_count", 128'(lg.size()), 128'(4));
        chk_test1_log("t5_data", 0);

        // Single-beat blocks on the 128-bit instance
        act = 1; beat = 0; blk = 0; km = '0; bm = 1'b0;
        lg.delete();
        send_block('1, {16{8'h0f}}, 1'b0);
        send_block('1, {16{8'h0f}}, 1'b0);
        drain();
        chk("t2_count", 128'(lg.size()), 128'(2));
        for (int i = 0; i < 2; i++)
            chk("t2_data", (i < lg.size()) ? lg[i] : 128'hx, {16{8'hf0}});
        chk("t2_blk", obc(1), 128'(2));

        // Random blocks with gaps on the 8-bit instance, counter wraps
        act = 2; beat = 0; blk = 0; km = '0; bm = 1'b0;
        pct = 70; vpct = 70;
        lg.delete();
        for (int b = 0; b < 5; b++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            send_block(st, key, 1'b0);
        end
        drain();
        chk("t6_count", 128'(lg.size()), 128'(80));
        chk("t6_blk", obc(2), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_roundkey_stream.md
Name: add_roundkey_stream

Overview:
Parametrised, streaming successor of the combinational AddRoundKey stage. It accepts a 128-bit AES state as BEATS = 128/LANE_BITS lane-wide beats, MSB lane first, over a valid/ready handshake. Each beat is XORed with the matching slice of a 128-bit round key that is captured once per block. Results are emitted through a one-deep registered output stage, so the block can sit between serialised SubBytes/MixColumns datapaths in the narrow-datapath AES core.

Parameters:
LANE_BITS, 32, bits per beat; legal values are 8, 16, 32, 64 and 128 (BEATS = 128/LANE_BITS). Any other value triggers a $fatal at elaboration.
CNT_BITS, 16, width of the completed-block counter.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  input beat valid.
s_ready  out  1  input beat accepted when s_valid && s_ready.
s_data  in  LANE_BITS  state lane; beat 0 = state[127 -: LANE_BITS].
s_key  in  128  round key; sampled only on an accepted beat 0.
s_bypass  in  1  sampled only on an accepted beat 0; 1 = pass data through unmodified for the whole block.
m_valid  out  1  output beat valid.
m_ready  in  1  downstream accept.
m_data  out  LANE_BITS  s_data XOR key slice (or s_data when bypass is set).
m_last  out  1  high on the final beat (BEATS-1) of a block.
busy  out  1  high while beat_cnt != 0, i.e. a block is partially accepted.
blk_count  out  CNT_BITS  count of blocks fully accepted at the input; wraps modulo 2^CNT_BITS.

Behaviour:
- Reset (rst=1 at a clk edge):
  - m_valid=0, m_data=0, m_last=0, beat_cnt=0, key_q=0, bypass_q=0, blk_count=0.
  - s_ready=1 in the cycle after reset.
- Reset mid-block: the partial block is discarded and no m_last is produced for it. The next accepted beat is treated as beat 0.
- Handshake:
  - s_ready = !m_valid || m_ready (combinational). This gives full throughput of one beat per cycle.
  - m_data, m_valid and m_last hold stable while m_valid && !m_ready.
  - s_valid must not depend on s_ready.
- Latency: exactly 1 cycle from an accepted input beat to m_valid.
- Beat 0 accept:
  - key_q <= s_key and bypass_q <= s_bypass.
  - The output uses s_key[127 -: LANE_BITS] and s_bypass directly (same-cycle bypass of the key register).
- Beat i>0 accept: the output uses key_q[127 - i*LANE_BITS -: LANE_BITS] and bypass_q.
- beat_cnt:
  - Increments on each accepted beat and wraps from BEATS-1 to 0.
  - On the wrap, blk_count increments and the registered m_last=1 for that beat.
- LANE_BITS=128 (BEATS=1): every beat is beat 0, m_last is always 1 with m_valid, and busy is always 0.
- No accept (s_valid=0, or s_ready=0): beat_cnt, key_q and blk_count are unchanged. If m_ready=1, m_valid drops to 0.
- Simultaneous output pop and input accept: the register reloads with the new beat and m_valid stays 1 with no bubble.
- s_key and s_bypass changing mid-block have no effect on the current block.
- All XORs are bitwise with no carry; widths are exact and there is no truncation.

Test Plan:
1. LANE_BITS=32; state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; 4 back-to-back beats, m_ready=1 -> m_data 00102030, 40506070, 8090a0b0, c0d0e0f0 on consecutive cycles, 1 cycle after each input; m_last only on the 4th; blk_count=1.
2. LANE_BITS=128; state all ff, key 0f repeated; two consecutive blocks -> m_data f0f0...f0 each cycle, m_last=1 each beat, blk_count=2.
3. LANE_BITS=32, test 1 vectors; hold m_ready=0 for 3 cycles after the first output -> s_ready=0, m_data stays 00102030; release -> the remaining 3 beats follow in order with no loss or duplication.
4. LANE_BITS=32; change s_key to all ff after beat 0 and set s_bypass=1 on beat 2 -> outputs still match test 1. Next block with s_bypass=1 on beat 0 -> m_data equals s_data.
5. LANE_BITS=32; accept 2 beats, assert rst one cycle -> m_valid=0, busy=0, blk_count=0. Then send a full block with test 1 vectors -> correct 4-beat output starting at 00102030.
6. LANE_BITS=8, CNT_BITS=2; 5 blocks with random s_valid/m_ready gaps -> each output equals the software XOR model, m_last every 16 beats, blk_count wraps to 1.
